// File: rtl/ysyx_25040109_csr_file.sv
// Machine-mode CSR file: mstatus/mtvec/mscratch/mepc/mcause, 64-bit mcycle,
// read-only vendor/arch IDs. Combinational read, registered update with
// ecall > mret > csr_we priority.
module ysyx_25040109_csr_file #(
  parameter logic [31:0] MVENDORID   = 32'h79737978,
  parameter logic [31:0] MARCHID     = 32'd25040109,
  parameter logic [31:0] MSTATUS_RST = 32'h00001800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  input  logic        ecall,
  input  logic        mret,
  input  logic [31:0] trap_pc,
  output logic [31:0] csr_rdata,
  output logic [31:0] mepc,
  output logic [31:0] mtvec,
  output logic        csr_illegal
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;

  // Only MIE and MPIE are stored; MPP is hardwired to machine mode.
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;

  logic [31:0] mstatus_rd;
  logic        addr_ok;
  logic        addr_ro;
  logic [63:0] mcycle_inc;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mcycle_inc = mcycle_q + 64'd1;

  // Address decode and combinational read of current register state.
  always_comb begin
    csr_rdata = '0;
    addr_ok   = 1'b1;
    addr_ro   = 1'b0;
    unique case (csr_addr)
      A_MSTATUS:   csr_rdata = mstatus_rd;
      A_MTVEC:     csr_rdata = mtvec_q;
      A_MSCRATCH:  csr_rdata = mscratch_q;
      A_MEPC:      csr_rdata = mepc_q;
      A_MCAUSE:    csr_rdata = mcause_q;
      A_MCYCLE:    csr_rdata = mcycle_q[31:0];
      A_MCYCLEH:   csr_rdata = mcycle_q[63:32];
      A_MVENDORID: begin csr_rdata = MVENDORID; addr_ro = 1'b1; end
      A_MARCHID:   begin csr_rdata = MARCHID;   addr_ro = 1'b1; end
      default:     addr_ok = 1'b0;
    endcase
  end

  assign csr_illegal = !addr_ok || (csr_we && addr_ro);
  assign mepc        = mepc_q;
  assign mtvec       = mtvec_q;

  // Next-state: trap entry beats trap return beats a software write.
  // A write to one mcycle half overrides only that half of the incremented
  // count, so the other half still sees the carry.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_inc;
    if (ecall) begin
      mepc_d   = trap_pc & ~32'd3;
      mcause_d = 32'd11;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we && addr_ok && !addr_ro) begin
      unique case (csr_addr)
        A_MSTATUS: begin
          mie_d  = csr_wdata[3];
          mpie_d = csr_wdata[7];
        end
        A_MTVEC:    mtvec_d           = csr_wdata & ~32'd3;
        A_MSCRATCH: mscratch_d        = csr_wdata;
        A_MEPC:     mepc_d            = csr_wdata & ~32'd3;
        A_MCAUSE:   mcause_d          = csr_wdata;
        A_MCYCLE:   mcycle_d[31:0]    = csr_wdata;
        A_MCYCLEH:  mcycle_d[63:32]   = csr_wdata;
        default:    ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= MSTATUS_RST[3];
      mpie_q     <= MSTATUS_RST[7];
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
    end
  end

endmodule
